time_of_week_counter: RTL
=========================

# time_of_week_counter

Parametrised time-of-week counter for the alarm-clock datapath, and the successor to the current-time register. It divides the system clock into minute ticks with a configurable prescaler, and keeps BCD minutes, binary hours (0-23) and a day index (0 to NUM_DAYS-1) in the existing 15-bit packed time word. Over the previous generation it adds:
- range-checked loads with an error flag;
- manual minute/hour set inputs that do not ripple;
- registered rollover strobes for the alarm comparator and display logic.

## Interface
- TICKS_PER_MIN, 128: clock cycles per minute; legal range 2..65536. Prescaler width PW = clog2(TICKS_PER_MIN).
- NUM_DAYS, 7: days per week; legal range 2..8, so the day field stays 3 bits.
- Clk  in  1  system clock; all state changes on its rising edge.
- Clr_N  in  1  reset: asynchronous, active-low; clears all state and outputs.
- Clr_CT  in  1  synchronous clear of time, prescaler, strobes and Load_Err.
- LD_CT  in  1  synchronous load request for CTI.
- CTI  in  15  load word: [3:0] minute units (BCD), [6:4] minute tens, [11:7] hours (binary), [14:12] day.
- EN_CT  in  1  run enable for the prescaler.
- Inc_Min  in  1  manual minute set: +1 minute, no carry into hours.
- Inc_Hr  in  1  manual hour set: +1 hour, no carry into days.
- CTO  out  15  current time, same packing as CTI.
- Min_Tick  out  1  one-cycle pulse on every natural minute advance.
- Hr_Roll  out  1  one-cycle pulse on a natural minute wrap 59->00.
- Day_Roll  out  1  one-cycle pulse on a natural wrap 23:59->00:00.
- Load_Err  out  1  sticky flag: the last load request was out of range.

## Operation
- **Priority per cycle:** Clr_CT > LD_CT > (Inc_Min/Inc_Hr) > natural advance. A lower-priority action is dropped in any cycle where a higher one fires, with one exception noted under the prescaler below.
- **Prescaler:**
  - PW-bit counter that increments only when EN_CT=1.
  - At TICKS_PER_MIN-1 it wraps to 0 and generates a natural advance.
  - EN_CT=0 holds the prescaler and the time; manual set inputs still act.
  - Manual set does not alter the prescaler. If the wrap coincides with Inc_Min or Inc_Hr, the prescaler still wraps but the natural advance is discarded.
- **Natural advance:**
  - Minute units 0..9; at 9 the units go to 0 and the tens increment.
  - Minute tens 0..5; at 5 with units 9 the tens go to 0 and the hour increments.
  - Hours 0..23; at 23:59 the hours go to 0 and the day increments.
  - Day wraps from NUM_DAYS-1 to 0.
- **Manual set:**
  - Inc_Min advances the minute 59->00 with no hour change.
  - Inc_Hr advances the hour 23->0 with no day change.
  - Both asserted in one cycle: both fields advance independently.
  - Manual set produces no strobes.
- **Load validation:** units<=9, tens<=5, hours<=23, day<=NUM_DAYS-1.
  - Valid: all fields are loaded, the prescaler is cleared and Load_Err goes to 0.
  - Invalid: time and prescaler are unchanged and Load_Err goes to 1.
  - A load never produces strobes.
- **Load_Err** clears only on a valid load, Clr_CT or Clr_N.
- **Clr_CT:** time = day 0, 00:00; prescaler 0; strobes 0; Load_Err 0.

## Timing
- **Reset:** asserting Clr_N forces immediately, without a clock edge: CTO=0, prescaler=0, Min_Tick=Hr_Roll=Day_Roll=0, Load_Err=0.
- **Reset release:** the first prescaler increment happens on the first rising edge at which Clr_N=1 and EN_CT=1.
- **Advance timing:** with EN_CT held high from reset, the first minute advance lands on rising edge number TICKS_PER_MIN. Subsequent advances follow every TICKS_PER_MIN edges.
- **Strobes:** registered and high for exactly one cycle, in the same cycle in which CTO first shows the advanced value.
  - Hr_Roll implies Min_Tick.
  - Day_Roll implies Hr_Roll.
- **Load, clear and manual set:** each takes effect at the edge where it is sampled, so CTO updates on the next cycle (one-cycle latency). Load_Err updates at the same edge.
- **Held inputs:** LD_CT held high reloads every cycle and keeps the prescaler at 0. Inc_Min or Inc_Hr held high advances once per cycle.
- **Combinational paths:** there is no combinational path from inputs to outputs.

## Test plan
- **Tick and rollover (TICKS_PER_MIN=4, NUM_DAYS=7):** reset, load day 6 23:58, EN_CT=1 for 8 cycles. Expected: CTO reads 23:59 after edge 4 with Min_Tick; 00:00 day 0 after edge 8 with Min_Tick, Hr_Roll and Day_Roll all pulsed one cycle.
- **Invalid load:** load minute units 10 (CTI[3:0]=4'hA) while time is 12:34. Expected: CTO stays 12:34 and Load_Err=1. A following valid load of 07:05 gives CTO=07:05 and Load_Err=0.
- **Manual set:** at 10:59, pulse Inc_Min. Expected: 10:00, no strobes. At 23:00, pulse Inc_Hr. Expected: 00:00 on the same day, no strobes.
- **Collision:** assert Inc_Min exactly on the prescaler wrap edge at 05:10. Expected: CTO=05:11 (a single advance), no Min_Tick, prescaler at 0.
- **Priority and enable:** assert Clr_CT, LD_CT and Inc_Hr together. Expected: CTO=0. With EN_CT=0 for 20 cycles, CTO and prescaler are unchanged.
- **Async reset mid-count:** assert Clr_N between clock edges at day 3 14:27 with prescaler=2. Expected: CTO=0 and all outputs 0 before the next edge; counting restarts 4 edges after release.

Source files
------------

// File: rtl/time_of_week_counter.sv
// ============================================================================
// time_of_week_counter : prescaled BCD-minute / hour / day time-of-week counter
// Revision: 1.0
// ============================================================================
`default_nettype none

module time_of_week_counter #(
    parameter int TICKS_PER_MIN = 128,
    parameter int NUM_DAYS      = 7
) (
    input  logic        Clk,
    input  logic        Clr_N,
    input  logic        Clr_CT,
    input  logic        LD_CT,
    input  logic [14:0] CTI,
    input  logic        EN_CT,
    input  logic        Inc_Min,
    input  logic        Inc_Hr,
    output logic [14:0] CTO,
    output logic        Min_Tick,
    output logic        Hr_Roll,
    output logic        Day_Roll,
    output logic        Load_Err
);

    localparam int            PW       = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_MIN - 1);
    localparam logic [2:0]    DAY_LAST = 3'(NUM_DAYS - 1);

    logic [PW-1:0] pre;
    logic [3:0]    min_u;
    logic [2:0]    min_t;
    logic [4:0]    hour;
    logic [2:0]    day;
    logic          min_tick;
    logic          hr_roll;
    logic          day_roll;
    logic          load_err;

    logic          pre_wrap;
    logic [PW-1:0] pre_next;
    logic          units_last;
    logic          tens_last;
    logic          hour_last;
    logic          min_wrap;
    logic          hour_wrap;
    logic [3:0]    adv_u;
    logic [2:0]    adv_t;
    logic [4:0]    inc_h;
    logic [4:0]    adv_h;
    logic [2:0]    adv_d;
    logic          load_ok;
    logic          manual;

    always_comb begin
        pre_wrap   = EN_CT && (pre == PRE_LAST);
        pre_next   = pre_wrap ? '0 : pre + PW'(1);

        units_last = (min_u == 4'd9);
        tens_last  = (min_t == 3'd5);
        hour_last  = (hour == 5'd23);
        min_wrap   = units_last && tens_last;
        hour_wrap  = min_wrap && hour_last;

        // Minute fields are shared by the natural and manual paths; only the
        // natural path lets the minute wrap carry onward.
        adv_u      = units_last ? 4'd0 : min_u + 4'd1;
        adv_t      = units_last ? (tens_last ? 3'd0 : min_t + 3'd1) : min_t;
        inc_h      = hour_last ? 5'd0 : hour + 5'd1;
        adv_h      = min_wrap ? inc_h : hour;
        adv_d      = hour_wrap ? ((day == DAY_LAST) ? 3'd0 : day + 3'd1) : day;

        load_ok    = (CTI[3:0] <= 4'd9) && (CTI[6:4] <= 3'd5) &&
                     (CTI[11:7] <= 5'd23) && (CTI[14:12] <= DAY_LAST);
        manual     = Inc_Min || Inc_Hr;
    end

    always_ff @(posedge Clk or negedge Clr_N) begin
        if (!Clr_N) begin
            pre      <= '0;
            min_u    <= 4'd0;
            min_t    <= 3'd0;
            hour     <= 5'd0;
            day      <= 3'd0;
            min_tick <= 1'b0;
            hr_roll  <= 1'b0;
            day_roll <= 1'b0;
            load_err <= 1'b0;
        end else if (Clr_CT) begin
            pre      <= '0;
            min_u    <= 4'd0;
            min_t    <= 3'd0;
            hour     <= 5'd0;
            day      <= 3'd0;
            min_tick <= 1'b0;
            hr_roll  <= 1'b0;
            day_roll <= 1'b0;
            load_err <= 1'b0;
        end else begin
            min_tick <= 1'b0;
            hr_roll  <= 1'b0;
            day_roll <= 1'b0;
            if (LD_CT) begin
                // A rejected load freezes the prescaler along with the time.
                if (load_ok) begin
                    min_u    <= CTI[3:0];
                    min_t    <= CTI[6:4];
                    hour     <= CTI[11:7];
                    day      <= CTI[14:12];
                    pre      <= '0;
                    load_err <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else begin
                if (EN_CT) begin
                    pre <= pre_next;
                end
                if (manual) begin
                    if (Inc_Min) begin
                        min_u <= adv_u;
                        min_t <= adv_t;
                    end
                    if (Inc_Hr) begin
                        hour <= inc_h;
                    end
                end else if (pre_wrap) begin
                    min_u    <= adv_u;
                    min_t    <= adv_t;
                    hour     <= adv_h;
                    day      <= adv_d;
                    min_tick <= 1'b1;
                    hr_roll  <= min_wrap;
                    day_roll <= hour_wrap;
                end
            end
        end
    end

    assign CTO      = {day, hour, min_t, min_u};
    assign Min_Tick = min_tick;
    assign Hr_Roll  = hr_roll;
    assign Day_Roll = day_roll;
    assign Load_Err = load_err;

endmodule

`default_nettype wire
